// File: rtl/alien_shot_scheduler.sv
// alien_shot_scheduler
//   Schedules alien return fire. Owns a fixed pool of enemy bullet slots,
//   picks the next living column round-robin, enforces a frame cooldown
//   between shots, moves active bullets downward each frame and retires
//   them on a hit or once they would pass the last visible row.
//
// Ports
//   Reset         async, active-high; clears all state
//   frame_clk     frame-rate clock, all updates on its rising edge
//   game_active   high while a wave is in play
//   col_alive     bit c high = column c has at least one living alien
//   col_bottom_Y  flattened, [10c+9:10c] = Y of lowest living alien in column c
//   swarm_X       X of column 0 origin
//   slot_hit      bit s high = slot s collided this frame
//   slot_active   bit s high = slot s bullet on screen
//   slot_X        flattened X per slot
//   slot_Y        flattened Y per slot
//   fire_pulse    one-frame pulse when a shot launches
//   fire_col      column chosen for the launch (valid with fire_pulse)
module alien_shot_scheduler #(
   parameter int NUM_COLS  = 11,
   parameter int NUM_SLOTS = 3,
   parameter int COOLDOWN  = 32,
   parameter int COL_PITCH = 32,
   parameter int X_OFFSET  = 8,
   parameter int Y_STEP    = 2,
   parameter int Y_LIMIT   = 479
) (
   input  logic                      Reset,
   input  logic                      frame_clk,
   input  logic                      game_active,
   input  logic [NUM_COLS-1:0]       col_alive,
   input  logic [10*NUM_COLS-1:0]    col_bottom_Y,
   input  logic [9:0]                swarm_X,
   input  logic [NUM_SLOTS-1:0]      slot_hit,
   output logic [NUM_SLOTS-1:0]      slot_active,
   output logic [10*NUM_SLOTS-1:0]   slot_X,
   output logic [10*NUM_SLOTS-1:0]   slot_Y,
   output logic                      fire_pulse,
   output logic [3:0]                fire_col
);

   localparam int              CW        = $clog2(COOLDOWN + 1);
   localparam logic [CW-1:0]   CD_LOAD   = CW'(COOLDOWN);
   localparam logic [4:0]      NC5       = 5'(NUM_COLS);
   localparam logic [3:0]      LAST_INIT = 4'(NUM_COLS - 1);
   localparam logic [9:0]      PITCH10   = 10'(COL_PITCH);
   localparam logic [9:0]      XOFF10    = 10'(X_OFFSET);
   localparam logic [9:0]      YSTEP10   = 10'(Y_STEP);
   localparam logic [10:0]     YLIM11    = 11'(Y_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      COOLING,
      ARMED
   } state_t;

   state_t             state;
   logic [CW-1:0]      cd_cnt;
   logic [3:0]         last_col;

   logic [NUM_SLOTS-1:0]   free_v;
   logic [NUM_SLOTS-1:0]   first_free;
   logic                   have_free;
   logic [2*NUM_COLS-1:0]  alive_dbl;
   logic [NUM_COLS-1:0]    alive_rot;
   logic [4:0]             pick_sum;
   logic [3:0]             pick_col;
   logic                   have_col;
   logic                   fire_go;
   logic [9:0]             launch_X;
   logic [9:0]             launch_Y;

   // Free slots are judged on the registered flags, so a slot retiring on
   // this edge is not reusable until the next one. x & (~x + 1) keeps only
   // the lowest set bit, i.e. the lowest-index free slot.
   always_comb begin
      free_v     = ~slot_active;
      first_free = free_v & (~free_v + NUM_SLOTS'(1));
      have_free  = |free_v;
   end

   // Round-robin column pick: rotate the alive mask so bit 0 is the column
   // after last_col, take the lowest set bit, then map back modulo NUM_COLS.
   always_comb begin
      alive_dbl = {col_alive, col_alive};
      alive_rot = NUM_COLS'(alive_dbl >> ({1'b0, last_col} + 5'd1));
      have_col  = |col_alive;
      pick_sum  = '0;
      for (int unsigned i = NUM_COLS; i > 0; i--) begin
         if (alive_rot[i-1]) begin
            pick_sum = {1'b0, last_col} + 5'd1 + 5'(i - 1);
         end
      end
      pick_col = (pick_sum >= NC5) ? 4'(pick_sum - NC5) : 4'(pick_sum);

      launch_Y = '0;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
         if (pick_col == 4'(c)) begin
            launch_Y = col_bottom_Y[10*c +: 10];
         end
      end
      launch_X = swarm_X + 10'(pick_col) * PITCH10 + XOFF10;
   end

   assign fire_go = (state == ARMED) && game_active && have_free && have_col;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         cd_cnt      <= CD_LOAD;
         last_col    <= LAST_INIT;
         slot_active <= '0;
         slot_X      <= '0;
         slot_Y      <= '0;
         fire_pulse  <= 1'b0;
         fire_col    <= '0;
      end else if (!game_active) begin
         state       <= IDLE;
         cd_cnt      <= CD_LOAD;
         slot_active <= '0;
         slot_X      <= '0;
         slot_Y      <= '0;
         fire_pulse  <= 1'b0;
      end else begin
         fire_pulse <= fire_go;

         // A slot being loaded does not move this edge; hit takes priority
         // over motion, and the floor test is done in 11 bits to avoid wrap.
         for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (fire_go && first_free[s]) begin
               slot_active[s]       <= 1'b1;
               slot_X[10*s +: 10]   <= launch_X;
               slot_Y[10*s +: 10]   <= launch_Y;
            end else if (slot_active[s]) begin
               if (slot_hit[s] ||
                   (({1'b0, slot_Y[10*s +: 10]} + {1'b0, YSTEP10}) > YLIM11)) begin
                  slot_active[s] <= 1'b0;
               end else begin
                  slot_Y[10*s +: 10] <= slot_Y[10*s +: 10] + YSTEP10;
               end
            end
         end

         case (state)
            IDLE: begin
               state <= COOLING;
            end
            COOLING: begin
               cd_cnt <= cd_cnt - CW'(1);
               if (cd_cnt == CW'(1)) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (fire_go) begin
                  fire_col <= pick_col;
                  last_col <= pick_col;
                  cd_cnt   <= CD_LOAD;
                  state    <= COOLING;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
